psa_seq_ctrl: RTL and testbench

Sequenced partitioned saturating adder for the PADDSB datapath. Accepts a 16-bit operand pair over a valid/ready handshake and processes one 4-bit lane per cycle, lane 0 first, using a single shared 4-bit saturating lane adder. It returns the packed saturated sum and a sticky overflow flag over a second valid/ready handshake. The block sits between the execute-stage issue logic and writeback, trading latency for a quarter of the adder area.

---
 rtl/psa_pkg.sv | 20 ++
 rtl/sat_add4.sv | 26 ++
 rtl/psa_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_psa_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psa_pkg.sv
// Shared constants and types for the sequenced partitioned saturating adder.
// Lane geometry, FSM state encoding and saturation limits live here.
package psa_pkg;

    localparam int LANE_W    = 4;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = LANE_W * NUM_LANES;

    localparam logic [1:0] LAST_LANE = 2'(NUM_LANES - 1);

    localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sat_add4.sv
// Combinational signed 4-bit adder with saturation on overflow.
// Shared by all lanes; the controller feeds it one lane per cycle.
module sat_add4
    import psa_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum,
    output logic              ovfl
);

    logic [LANE_W-1:0] raw;

    // Raw add, overflow detect from sign bits, then clamp.
    always_comb begin
        raw  = a + b;
        ovfl = (a[LANE_W-1] == b[LANE_W-1]) &&
               (raw[LANE_W-1] != a[LANE_W-1]);
        if (ovfl) begin
            sum = raw[LANE_W-1] ? SAT_POS : SAT_NEG;
        end else begin
            sum = raw;
        end
    end

endmodule

// File: rtl/psa_seq_ctrl.sv
// Sequenced partitioned saturating adder: one 4-bit lane per cycle.
// Optional PSA_SEQ_LANE_ERR_EN adds per-lane overflow output err_lanes.
module psa_seq_ctrl
    import psa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] sum,
    output logic              error,
`ifdef PSA_SEQ_LANE_ERR_EN
    output logic [NUM_LANES-1:0] err_lanes,
`endif
    output logic              busy
);

    state_e            state_q, state_d;
    logic [1:0]        lane_idx_q, lane_idx_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              error_q, error_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
`ifdef PSA_SEQ_LANE_ERR_EN
    logic [NUM_LANES-1:0] err_lanes_q, err_lanes_d;
`endif

    logic [3:0]        lane_base;
    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    logic [LANE_W-1:0] lane_sum;
    logic              lane_ovfl;

    assign lane_base = {lane_idx_q, 2'b00};
    assign lane_a    = a_q[lane_base +: LANE_W];
    assign lane_b    = b_q[lane_base +: LANE_W];

    sat_add4 u_sat_add4 (
        .a    (lane_a),
        .b    (lane_b),
        .sum  (lane_sum),
        .ovfl (lane_ovfl)
    );

    // Next-state, lane sequencing and decoded handshake outputs.
    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        error_d    = error_q;
`ifdef PSA_SEQ_LANE_ERR_EN
        err_lanes_d = err_lanes_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d        = a;
                    b_d        = b;
                    sum_d      = '0;
                    error_d    = 1'b0;
                    lane_idx_d = 2'd0;
`ifdef PSA_SEQ_LANE_ERR_EN
                    err_lanes_d = '0;
`endif
                    state_d    = CALC;
                end
            end
            CALC: begin
                sum_d[lane_base +: LANE_W] = lane_sum;
                error_d    = error_q | lane_ovfl;
`ifdef PSA_SEQ_LANE_ERR_EN
                err_lanes_d[lane_idx_q] = lane_ovfl;
`endif
                lane_idx_d = lane_idx_q + 2'd1;
                if (lane_idx_q == LAST_LANE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // All state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_idx_q  <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            error_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PSA_SEQ_LANE_ERR_EN
            err_lanes_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            error_q     <= error_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef PSA_SEQ_LANE_ERR_EN
            err_lanes_q <= err_lanes_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign error     = error_q;
`ifdef PSA_SEQ_LANE_ERR_EN
    assign err_lanes = err_lanes_q;
`endif

endmodule

// File: tb/tb_psa_seq_ctrl.sv
// Self-checking bench for psa_seq_ctrl with a lane-arithmetic reference.
// Define PSA_SEQ_LANE_ERR_EN to also check err_lanes.
module tb_psa_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] sum;
    logic        error;
    logic [3:0]  err_lanes;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    psa_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .sum       (sum),
        .error     (error),
`ifdef PSA_SEQ_LANE_ERR_EN
        .err_lanes (err_lanes),
`endif
        .busy      (busy)
    );

`ifndef PSA_SEQ_LANE_ERR_EN
    assign err_lanes = 4'h0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: {lane_ovf[3:0], error, sum[15:0]} by integer clamping.
    function automatic logic [20:0] ref_psa(input logic [15:0] x,
                                            input logic [15:0] y);
        logic [15:0] s;
        logic [3:0]  ov;
        logic signed [3:0] lx, ly;
        int t;
        s  = '0;
        ov = '0;
        for (int i = 0; i < 4; i++) begin
            lx = x[4*i +: 4];
            ly = y[4*i +: 4];
            t  = int'(lx) + int'(ly);
            if (t > 7) begin
                t = 7;
                ov[i] = 1'b1;
            end else if (t < -8) begin
                t = -8;
                ov[i] = 1'b1;
            end
            s[4*i +: 4] = 4'(t);
        end
        return {ov, |ov, s};
    endfunction

    // Model: op_active, edges since accept, visible result.
    bit          started = 0;
    bit          m_active = 0;
    int          m_edges = 0;
    bit          m_show = 0;
    logic [20:0] m_res = '0;
    logic [20:0] m_vis = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            started  = 1;
            m_active = 0;
            m_show   = 1;
            m_vis    = '0;
        end else if (!m_active) begin
            if (req_valid) begin
                m_active = 1;
                m_edges  = 0;
                m_res    = ref_psa(a, b);
                m_show   = 0;
            end
        end else if (m_edges >= 4) begin
            if (rsp_ready) m_active = 0;
        end else begin
            m_edges++;
            if (m_edges == 4) begin
                m_vis  = m_res;
                m_show = 1;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", 32'(req_ready), 32'(!m_active));
            chk("busy", 32'(busy), 32'(m_active));
            chk("rsp_valid", 32'(rsp_valid),
                32'(m_active && m_edges >= 4));
            if (m_show) begin
                chk("sum", 32'(sum), 32'(m_vis[15:0]));
                chk("error", 32'(error), 32'(m_vis[16]));
`ifdef PSA_SEQ_LANE_ERR_EN
                chk("err_lanes", 32'(err_lanes), 32'(m_vis[20:17]));
`endif
            end
        end
    end

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_op(input string nm, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] es,
                         input logic ee, input logic [3:0] el);
        int lat;
        wait_idle();
        a = av;
        b = bv;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        wait_rsp(lat);
        chk({nm, "_lat"}, 32'(lat), 32'd5);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_err"}, 32'(error), 32'(ee));
`ifdef PSA_SEQ_LANE_ERR_EN
        chk({nm, "_lanes"}, 32'(err_lanes), 32'(el));
`else
        chk({nm, "_lanes_tie"}, 32'(el & err_lanes), 32'd0);
`endif
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        do_op("basic", 16'h1234, 16'h1111, 16'h2345, 1'b0, 4'h0);
        do_op("pos_sat", 16'h7777, 16'h1111, 16'h7777, 1'b1, 4'hF);
        do_op("neg_sat", 16'h8080, 16'h8F8F, 16'h8F8F, 1'b1, 4'b1010);

        // Consumer stall with a new request pending.
        wait_idle();
        a = 16'h1234;
        b = 16'h1111;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat);
        chk("stall_lat", 32'(lat), 32'd5);
        a = 16'h0001;
        b = 16'h0001;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_sum", 32'(sum), 32'h2345);
            chk("stall_err", 32'(error), 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_rel_ready", 32'(req_ready), 32'd1);
        chk("stall_rel_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat);
        chk("stall_next_lat", 32'(lat), 32'd5);
        chk("stall_next_sum", 32'(sum), 32'h0002);

        // Reset after lane 1 is written.
        wait_idle();
        a = 16'h1234;
        b = 16'h1111;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("partial_sum", 32'(sum), 32'h0045);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_err", 32'(error), 32'd0);
        do_op("post_rst", 16'h0001, 16'h0001, 16'h0002, 1'b0, 4'h0);

        do_op("b2b_a", 16'h7000, 16'h1000, 16'h7000, 1'b1, 4'b1000);
        do_op("b2b_b", 16'h0001, 16'h0002, 16'h0003, 1'b0, 4'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
